lock_sequencer: RTL
===================

Name: lock_sequencer

Overview:
- FSM controller for the keypad door-lock datapath: keypad encoder, two 8-digit BCD shift-register arrays (setpoint SP, user-input UI), 32-bit equality comparator, attempt counter.
- Replaces the free-running T-FF clocking and manual resets with single-cycle shift enables, register clears, compare sequencing, unlock timing and lockout after repeated failures.
- Sits between the encoder/mode select and both register arrays.

Parameters:
- DIGITS, 8: digits per code; sets digit counter terminal value.
- MAX_ATTEMPTS, 3: consecutive failed compares that trigger lockout (1..9).
- UNLOCK_CYCLES, 16: clocks `unlock` stays high.
- LOCKOUT_CYCLES, 64: clocks `alarm` stays high; keys are ignored for this period.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- key_valid, input, 1: encoder valid flag (encoder out[4]); level, high while a key is held.
- key_code, input, 4: encoder BCD digit (encoder out[3:0]); informational, not stored here.
- mode_sel, input, 1: 0 = user entry, 1 = program setpoint.
- comp_eq, input, 1: comparator result, UI == SP.
- ui_shift_en, output, 1: one-cycle shift pulse to UI array.
- sp_shift_en, output, 1: one-cycle shift pulse to SP array.
- ui_clr, output, 1: one-cycle clear to UI array.
- sp_clr, output, 1: one-cycle clear to SP array.
- unlock, output, 1: door release.
- alarm, output, 1: lockout indicator.
- sp_loaded, output, 1: a complete setpoint is stored.
- attempt_count, output, 4: BCD count of consecutive failures.
- state_out, output, 3: current FSM state encoding, for debug.

Behaviour:
- Reset: asynchronous, active-low; all outputs 0; state IDLE; digit_cnt 0; press-detect register 0.
- All outputs are registered.
- Press detection:
  - press = key_valid & ~key_prev, where key_prev is key_valid registered.
  - A held key yields exactly one press.
  - A key already held when rst_n deasserts yields no press.
- Shift latency: a press sampled at edge N drives the shift enable high from edge N+1 to edge N+2.
- IDLE (000):
  - press with mode_sel=1: pulse sp_shift_en; digit_cnt=1; latch mode=SP; go to ENTRY.
  - press with mode_sel=0 and sp_loaded=1: pulse ui_shift_en; digit_cnt=1; latch mode=UI; go to ENTRY.
  - press with mode_sel=0 and sp_loaded=0: ignored.
- ENTRY (001):
  - Each press pulses the latched mode's shift enable and increments digit_cnt.
  - mode_sel is ignored until return to IDLE.
  - When digit_cnt reaches DIGITS in SP mode: set sp_loaded; go to IDLE.
  - When digit_cnt reaches DIGITS in UI mode: go to COMPARE.
  - Starting SP entry clears sp_loaded in the same cycle as the first sp_shift_en.
- COMPARE (010):
  - One wait cycle for shift settle; comp_eq is sampled on the second cycle.
  - comp_eq=1: attempt_count=0; go to UNLOCK.
  - comp_eq=0: attempt_count+1. If the new value equals MAX_ATTEMPTS, go to LOCKOUT; else go to CLEAR.
- CLEAR (011): pulse ui_clr for 1 cycle; go to IDLE.
- UNLOCK (100): unlock=1 for exactly UNLOCK_CYCLES cycles; then go to CLEAR.
- LOCKOUT (101): alarm=1 for exactly LOCKOUT_CYCLES cycles; then attempt_count=0; go to CLEAR.
- Presses in COMPARE, CLEAR, UNLOCK or LOCKOUT are dropped, never queued.
- attempt_count is BCD and saturates at 9. It persists across successful SP reprogramming; only a successful unlock, lockout expiry or reset clears it.
- Reset mid-operation: everything returns to reset values, including sp_loaded=0. The arrays are not cleared by this block.
- No two of ui_shift_en, sp_shift_en, ui_clr and sp_clr are ever high together.
- sp_clr is asserted only on entering SP ENTRY from IDLE, one cycle before the first sp_shift_en. To allow this, the first sp_shift_en is delayed one cycle in SP mode only.
- Timer width is clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES)) + 1.

Decomposition:
- Shared package holds:
  - state encodings IDLE, ENTRY, COMPARE, CLEAR, UNLOCK, LOCKOUT;
  - mode constants MODE_UI=0, MODE_SP=1;
  - default parameter values.
- One natural sub-module: key_press_detect (edge detector on key_valid producing a one-cycle press).
- Timer and counters stay inline.

Test Plan:
- Reset, then 8 presses with mode_sel=1 (digits 2,1,9,3,5,4,8,8) -> sp_clr once, then 8 sp_shift_en pulses; sp_loaded=1; state IDLE.
- sp_loaded=0, user presses with mode_sel=0 -> no ui_shift_en; state stays IDLE.
- Program SP, then enter a matching 8-digit UI code -> COMPARE for 2 cycles; unlock high for exactly 16 cycles; one ui_clr; attempt_count=0.
- Three wrong 8-digit UI codes -> attempt_count goes 1, 2, 3; alarm for 64 cycles; presses during alarm produce no shifts; afterwards attempt_count=0.
- key_valid held high for 20 cycles, then a 1-cycle key_valid glitch -> exactly two shift pulses.
- rst_n pulled low mid-ENTRY (after 4 digits) -> all outputs 0 asynchronously; sp_loaded=0; next press starts digit_cnt at 1.

Source files
------------

// File: rtl/lock_sequencer_pkg.sv
// Shared definitions for the keypad door-lock sequencer.
// Holds the FSM state encodings (also exported on state_out for debug),
// the entry-mode constants and the default parameter values.
package lock_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StEntry   = 3'd1,
        StCompare = 3'd2,
        StClear   = 3'd3,
        StUnlock  = 3'd4,
        StLockout = 3'd5
    } state_e;

    localparam logic MODE_UI = 1'b0;
    localparam logic MODE_SP = 1'b1;

    localparam int unsigned DefDigits        = 8;
    localparam int unsigned DefMaxAttempts   = 3;
    localparam int unsigned DefUnlockCycles  = 16;
    localparam int unsigned DefLockoutCycles = 64;

    // Wide enough to hold the longer of the unlock and lockout periods.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/lock_sequencer_if.sv
// Bundle between the sequencer and the keypad datapath.
//   key_valid/key_code : encoder outputs (key_code is consumed by the arrays only)
//   mode_sel           : 0 = user entry, 1 = program setpoint
//   comp_eq            : comparator result UI == SP
//   *_shift_en, *_clr  : single-cycle controls to the UI/SP arrays
//   unlock, alarm      : door release and lockout indicator
//   sp_loaded          : complete setpoint stored
//   attempt_count      : BCD count of consecutive failures
//   state_out          : FSM state for debug
// master = datapath/encoder side, slave = sequencer.
interface lock_sequencer_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       mode_sel;
    logic       comp_eq;
    logic       ui_shift_en;
    logic       sp_shift_en;
    logic       ui_clr;
    logic       sp_clr;
    logic       unlock;
    logic       alarm;
    logic       sp_loaded;
    logic [3:0] attempt_count;
    logic [2:0] state_out;

    modport master (
        output key_valid, key_code, mode_sel, comp_eq,
        input  ui_shift_en, sp_shift_en, ui_clr, sp_clr, unlock, alarm, sp_loaded,
               attempt_count, state_out
    );

    // key_code is not needed by the sequencer, so it is left out of this view.
    modport slave (
        input  key_valid, mode_sel, comp_eq,
        output ui_shift_en, sp_shift_en, ui_clr, sp_clr, unlock, alarm, sp_loaded,
               attempt_count, state_out
    );
endinterface

// File: rtl/lock_sequencer_press.sv
// key_press_detect: turns the level key_valid into a registered one-cycle press.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_key_valid  : encoder valid level
//   o_press      : one-cycle pulse, one clock after the rising edge is sampled
module key_press_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_valid,
    output logic o_press
);
    logic r_key_prev;
    logic r_armed;
    logic r_press;

    // r_armed stays low until key_valid has been seen low once, so a key
    // already held when reset releases never produces a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_prev <= 1'b0;
            r_armed    <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            r_key_prev <= i_key_valid;
            r_armed    <= r_armed | ~i_key_valid;
            r_press    <= i_key_valid & ~r_key_prev & r_armed;
        end
    end

    assign o_press = r_press;
endmodule

// File: rtl/lock_sequencer.sv
// lock_sequencer: controller for the keypad door lock.
//   clk, rst_n : clock, asynchronous active-low reset
//   io_bus     : slave view of lock_sequencer_if (keypad inputs, array controls,
//                unlock/alarm, status)
// Generates shift/clear pulses for the SP and UI arrays, sequences the compare,
// times the unlock and lockout windows and counts consecutive failures.
module lock_sequencer
    import lock_sequencer_pkg::*;
#(
    parameter int unsigned DIGITS         = DefDigits,
    parameter int unsigned MAX_ATTEMPTS   = DefMaxAttempts,
    parameter int unsigned UNLOCK_CYCLES  = DefUnlockCycles,
    parameter int unsigned LOCKOUT_CYCLES = DefLockoutCycles
) (
    input logic             clk,
    input logic             rst_n,
    lock_sequencer_if.slave io_bus
);
    localparam int unsigned TimerW = timer_width(UNLOCK_CYCLES, LOCKOUT_CYCLES);
    localparam int unsigned CntW   = $clog2(DIGITS + 1);

    localparam logic [CntW-1:0]   CntLast    = CntW'(DIGITS);
    localparam logic [3:0]        AttMax     = 4'(MAX_ATTEMPTS);
    localparam logic [TimerW-1:0] UnlockLoad = TimerW'(UNLOCK_CYCLES - 1);
    localparam logic [TimerW-1:0] LockLoad   = TimerW'(LOCKOUT_CYCLES - 1);

    state_e            r_state, w_state_d;
    logic              r_mode, w_mode_d;
    logic              r_pend, w_pend_d;
    logic [CntW-1:0]   r_cnt, w_cnt_d;
    logic [TimerW-1:0] r_timer, w_timer_d;
    logic [3:0]        r_att, w_att_d;
    logic              r_sp_loaded, w_sp_loaded_d;
    logic              r_unlock, w_unlock_d;
    logic              r_alarm, w_alarm_d;
    logic              r_ui_shift, w_ui_shift_d;
    logic              r_sp_shift, w_sp_shift_d;
    logic              r_ui_clr, w_ui_clr_d;
    logic              r_sp_clr, w_sp_clr_d;

    logic              w_press;
    logic [CntW-1:0]   w_cnt_inc;
    logic [3:0]        w_att_inc;

    key_press_detect u_press (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_key_valid (io_bus.key_valid),
        .o_press     (w_press)
    );

    assign w_cnt_inc = r_cnt + CntW'(1);
    // BCD count saturating at 9.
    assign w_att_inc = (r_att >= 4'd9) ? 4'd9 : r_att + 4'd1;

    always_comb begin
        w_state_d     = r_state;
        w_mode_d      = r_mode;
        w_pend_d      = r_pend;
        w_cnt_d       = r_cnt;
        w_timer_d     = r_timer;
        w_att_d       = r_att;
        w_sp_loaded_d = r_sp_loaded;
        w_unlock_d    = r_unlock;
        w_alarm_d     = r_alarm;
        w_ui_shift_d  = 1'b0;
        w_sp_shift_d  = 1'b0;
        w_ui_clr_d    = 1'b0;
        w_sp_clr_d    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_press) begin
                    if (io_bus.mode_sel == MODE_SP) begin
                        // Clear first; the first shift follows next cycle.
                        w_sp_clr_d = 1'b1;
                        w_mode_d   = MODE_SP;
                        w_pend_d   = 1'b1;
                        w_cnt_d    = CntW'(1);
                        w_state_d  = StEntry;
                    end else if (r_sp_loaded) begin
                        w_ui_shift_d = 1'b1;
                        w_mode_d     = MODE_UI;
                        w_cnt_d      = CntW'(1);
                        w_timer_d    = '0;
                        w_state_d    = (CntLast == CntW'(1)) ? StCompare : StEntry;
                    end
                end
            end
            StEntry: begin
                if (r_pend) begin
                    w_sp_shift_d  = 1'b1;
                    w_pend_d      = 1'b0;
                    w_sp_loaded_d = (r_cnt == CntLast);
                    if (r_cnt == CntLast) w_state_d = StIdle;
                end else if (w_press) begin
                    w_cnt_d = w_cnt_inc;
                    if (r_mode == MODE_SP) begin
                        w_sp_shift_d = 1'b1;
                        if (w_cnt_inc == CntLast) begin
                            w_sp_loaded_d = 1'b1;
                            w_state_d     = StIdle;
                        end
                    end else begin
                        w_ui_shift_d = 1'b1;
                        if (w_cnt_inc == CntLast) begin
                            w_timer_d = '0;
                            w_state_d = StCompare;
                        end
                    end
                end
            end
            StCompare: begin
                // First cycle lets the last shift settle; comp_eq used on the second.
                if (r_timer == '0) begin
                    w_timer_d = TimerW'(1);
                end else if (io_bus.comp_eq) begin
                    w_att_d    = 4'd0;
                    w_unlock_d = 1'b1;
                    w_timer_d  = UnlockLoad;
                    w_state_d  = StUnlock;
                end else begin
                    w_att_d = w_att_inc;
                    if (w_att_inc == AttMax) begin
                        w_alarm_d = 1'b1;
                        w_timer_d = LockLoad;
                        w_state_d = StLockout;
                    end else begin
                        w_ui_clr_d = 1'b1;
                        w_state_d  = StClear;
                    end
                end
            end
            StClear: begin
                w_state_d = StIdle;
            end
            StUnlock: begin
                if (r_timer == '0) begin
                    w_unlock_d = 1'b0;
                    w_ui_clr_d = 1'b1;
                    w_state_d  = StClear;
                end else begin
                    w_timer_d = r_timer - TimerW'(1);
                end
            end
            StLockout: begin
                if (r_timer == '0) begin
                    w_alarm_d  = 1'b0;
                    w_att_d    = 4'd0;
                    w_ui_clr_d = 1'b1;
                    w_state_d  = StClear;
                end else begin
                    w_timer_d = r_timer - TimerW'(1);
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_mode      <= MODE_UI;
            r_pend      <= 1'b0;
            r_cnt       <= '0;
            r_timer     <= '0;
            r_att       <= 4'd0;
            r_sp_loaded <= 1'b0;
            r_unlock    <= 1'b0;
            r_alarm     <= 1'b0;
            r_ui_shift  <= 1'b0;
            r_sp_shift  <= 1'b0;
            r_ui_clr    <= 1'b0;
            r_sp_clr    <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_mode      <= w_mode_d;
            r_pend      <= w_pend_d;
            r_cnt       <= w_cnt_d;
            r_timer     <= w_timer_d;
            r_att       <= w_att_d;
            r_sp_loaded <= w_sp_loaded_d;
            r_unlock    <= w_unlock_d;
            r_alarm     <= w_alarm_d;
            r_ui_shift  <= w_ui_shift_d;
            r_sp_shift  <= w_sp_shift_d;
            r_ui_clr    <= w_ui_clr_d;
            r_sp_clr    <= w_sp_clr_d;
        end
    end

    assign io_bus.ui_shift_en   = r_ui_shift;
    assign io_bus.sp_shift_en   = r_sp_shift;
    assign io_bus.ui_clr        = r_ui_clr;
    assign io_bus.sp_clr        = r_sp_clr;
    assign io_bus.unlock        = r_unlock;
    assign io_bus.alarm         = r_alarm;
    assign io_bus.sp_loaded     = r_sp_loaded;
    assign io_bus.attempt_count = r_att;
    assign io_bus.state_out     = r_state;
endmodule
